bitsum_tree_pipe: RTL and testbench



---
 rtl/bitsum_pkg.sv | 25 ++
 rtl/bitsum_node.sv | 12 +
 rtl/bitsum_tree_pipe.sv | 76 +++++++
 tb/tb_bitsum_tree_pipe.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/bitsum_pkg.sv
// Width and tree-shape helpers shared by the population-count adder tree.
package bitsum_pkg;

    function automatic int unsigned clog2_u(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++)
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        return r;
    endfunction

    function automatic int unsigned count_w(input int unsigned n);
        return clog2_u(n + 1);
    endfunction

    function automatic int unsigned num_levels(input int unsigned n);
        return clog2_u(n);
    endfunction

    // Operands present at tree level l: ceil(n / 2^l).
    function automatic int unsigned ops_at_level(input int unsigned n, input int unsigned l);
        return 32'((64'(n) + (64'd1 << l) - 64'd1) >> l);
    endfunction

endpackage

// File: rtl/bitsum_node.sv
// One adder-tree node: unsigned W-bit + W-bit sum with a carry bit.
module bitsum_node #(
    parameter int unsigned W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   s
);

    always_comb s = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/bitsum_tree_pipe.sv
// Registered population count of an N-bit vector via a balanced adder tree.
// Define BITSUM_TREE_PIPELINE_EN to register every adder level (latency LEVELS+1).
module bitsum_tree_pipe
    import bitsum_pkg::*;
#(
    parameter int unsigned N     = 9,
    parameter int unsigned OUT_W = count_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N-1:0]     in,
    output logic             out_valid,
    output logic [OUT_W-1:0] out
);

    localparam int unsigned LEVELS = num_levels(N);

    // Level l holds ceil(N/2^l) operands of width l+1; level 0 is the raw input bits.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int unsigned NOPS = ops_at_level(N, l);
        logic [l:0] op [NOPS];
        logic       vld;

        if (l == 0) begin : g_in
            always_comb begin
                for (int unsigned i = 0; i < N; i++) op[i] = in[i];
                vld = in_valid;
            end
        end else begin : g_add
            localparam int unsigned PREV = ops_at_level(N, l - 1);
            logic [l:0] sum [NOPS];

            for (genvar p = 0; p < NOPS; p++) begin : g_pair
                if (2 * p + 1 < PREV) begin : g_node
                    bitsum_node #(.W(l)) u_node (
                        .a (g_lvl[l-1].op[2*p]),
                        .b (g_lvl[l-1].op[2*p+1]),
                        .s (sum[p])
                    );
                end else begin : g_pass
                    always_comb sum[p] = {1'b0, g_lvl[l-1].op[2*p]};
                end
            end

`ifdef BITSUM_TREE_PIPELINE_EN
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld <= 1'b0;
                    for (int unsigned i = 0; i < NOPS; i++) op[i] <= '0;
                end else begin
                    vld <= g_lvl[l-1].vld;
                    if (g_lvl[l-1].vld) op <= sum;
                end
            end
`else
            always_comb begin
                op  = sum;
                vld = g_lvl[l-1].vld;
            end
`endif
        end
    end

    // Data loads only on a qualified sample, so X on an idle input never reaches out.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            out_valid <= g_lvl[LEVELS].vld;
            if (g_lvl[LEVELS].vld) out <= OUT_W'(g_lvl[LEVELS].op[0]);
        end
    end

endmodule

// File: tb/tb_bitsum_tree_pipe.sv
// Self-checking bench for bitsum_tree_pipe: directed table, random stream, reset and width sweep.
module tb_bitsum_tree_pipe;

    localparam int MAXC = 512;
`ifdef BITSUM_TREE_PIPELINE_EN
    localparam int LAT = $clog2(9) + 1;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [8:0] in;
    logic       out_valid;
    logic [3:0] out;

    logic        sw_v;
    logic [0:0]  s1_in;  logic s1_ov;  logic [0:0] s1_out;
    logic [1:0]  s2_in;  logic s2_ov;  logic [1:0] s2_out;
    logic [7:0]  s8_in;  logic s8_ov;  logic [3:0] s8_out;
    logic [15:0] s16_in; logic s16_ov; logic [4:0] s16_out;

    always #5 clk = ~clk;

    bitsum_tree_pipe #(.N(9)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in),
        .out_valid(out_valid), .out(out)
    );
    bitsum_tree_pipe #(.N(1)) dut_n1 (
        .clk(clk), .rst(rst), .in_valid(sw_v), .in(s1_in),
        .out_valid(s1_ov), .out(s1_out)
    );
    bitsum_tree_pipe #(.N(2)) dut_n2 (
        .clk(clk), .rst(rst), .in_valid(sw_v), .in(s2_in),
        .out_valid(s2_ov), .out(s2_out)
    );
    bitsum_tree_pipe #(.N(8)) dut_n8 (
        .clk(clk), .rst(rst), .in_valid(sw_v), .in(s8_in),
        .out_valid(s8_ov), .out(s8_out)
    );
    bitsum_tree_pipe #(.N(16)) dut_n16 (
        .clk(clk), .rst(rst), .in_valid(sw_v), .in(s16_in),
        .out_valid(s16_ov), .out(s16_out)
    );

    typedef struct {
        logic [8:0] vec;
        int         cnt;
    } vec_t;
    vec_t tbl [5];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // Per-cycle history of what was driven; the model derives outputs from it.
    logic hr [MAXC];
    logic hv [MAXC];
    int   hc [MAXC];
    logic [3:0] mo = '0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    endtask

    // Drive one cycle, then compare against the model: a sample accepted at edge j
    // appears after edge j+LAT-1 unless any reset edge fell in that window.
    task automatic step(input logic r, input logic v, input logic [8:0] d, input int c);
        int   j;
        logic ev;
        rst = r; in_valid = v; in = d;
        hr[cyc] = r; hv[cyc] = v; hc[cyc] = c;
        @(posedge clk); #1;
        j  = cyc - LAT + 1;
        ev = 1'b0;
        if (j >= 0) begin
            ev = hv[j];
            for (int i = j; i <= cyc; i++) if (hr[i]) ev = 1'b0;
        end
        if (r) mo = '0;
        else if (ev) mo = 4'(hc[j]);
        check("out_valid", 8'(out_valid), 8'(ev));
        check("out", 8'(out), 8'(mo));
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [8:0] d;
        logic       v;
        int         lat;

        tbl[0] = '{9'b000000000, 0};
        tbl[1] = '{9'b000000100, 1};
        tbl[2] = '{9'b111111111, 9};
        tbl[3] = '{9'b101010101, 5};
        tbl[4] = '{9'b100000000, 1};

        sw_v = 1'b1; s1_in = '1; s2_in = '1; s8_in = '1; s16_in = '1;

        // Reset held two cycles with a live all-ones input.
        step(1'b1, 1'b1, 9'h1FF, 9);
        step(1'b1, 1'b1, 9'h1FF, 9);

        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, tbl[i].vec, tbl[i].cnt);
        for (int i = 0; i < LAT; i++) step(1'b0, 1'b0, 9'bx, 0);

        // Valid gating: idle inputs must not move out.
        step(1'b0, 1'b1, 9'h1FF, 9);
        for (int i = 0; i < LAT; i++) step(1'b0, 1'b0, 9'b000000001, 1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 9'b000000001, 1);

        // Back-to-back random stream.
        for (int i = 0; i < 50; i++) begin
            d = 9'($urandom);
            step(1'b0, 1'b1, d, $countones(d));
        end
        // Random valid/idle mix with X on idle cycles.
        for (int i = 0; i < 40; i++) begin
            v = 1'($urandom_range(0, 1));
            d = 9'($urandom);
            if (v) step(1'b0, 1'b1, d, $countones(d));
            else   step(1'b0, 1'b0, 9'bx, 0);
        end

        // Mid-stream reset with samples in flight, then measure first latency.
        for (int i = 0; i < 3; i++) begin
            d = 9'($urandom);
            step(1'b0, 1'b1, d, $countones(d));
        end
        step(1'b1, 1'b1, 9'h0FF, 8);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 9'bx, 0);
        step(1'b0, 1'b1, 9'b011011011, 6);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            step(1'b0, 1'b0, 9'bx, 0);
            lat++;
        end
        check("post_reset_latency", 8'(lat), 8'(LAT));
        check("post_reset_value", 8'(out), 8'd6);

        for (int i = 0; i < LAT + 8; i++) step(1'b0, 1'b0, 9'bx, 0);

        // Width sweep: all-ones input counts to N.
        check("sweep_n1_valid", 8'(s1_ov), 8'd1);
        check("sweep_n1", 8'(s1_out), 8'd1);
        check("sweep_n2_valid", 8'(s2_ov), 8'd1);
        check("sweep_n2", 8'(s2_out), 8'd2);
        check("sweep_n8_valid", 8'(s8_ov), 8'd1);
        check("sweep_n8", 8'(s8_out), 8'd8);
        check("sweep_n16_valid", 8'(s16_ov), 8'd1);
        check("sweep_n16", 8'(s16_out), 8'd16);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
